peripheral_spram_axi4_initiator: RTL and testbench
==================================================

Name: peripheral_spram_axi4_initiator

Overview:
- Converts a native single-port memory request interface (req/we/addr/be/data) into single-beat AXI4 master transactions.
- It is the initiator-side counterpart of the SPRAM AXI4 responder.
- Processor-side or test-side logic drives SPRAM peripherals through the AXI4 fabric with it.
- One transaction is outstanding at a time; the result is returned as a one-cycle response pulse.

Parameters:
- AXI_ID_WIDTH, 10, width of the ID fields
- AXI_ADDR_WIDTH, 64, address width
- AXI_DATA_WIDTH, 64, data width
- AXI_STRB_WIDTH, 8, strobe width; must equal AXI_DATA_WIDTH/8
- AXI_USER_WIDTH, 10, width of the user fields
- AXI_ID, 0, constant ID driven on AW and AR

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active high
- req_i  in  1  native request valid
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AXI_ADDR_WIDTH  byte address
- be_i  in  AXI_STRB_WIDTH  byte enables
- wdata_i  in  AXI_DATA_WIDTH  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  one-cycle response pulse
- rdata_o  out  AXI_DATA_WIDTH  read data, valid with rvalid_o
- err_o  out  1  response was SLVERR/DECERR, valid with rvalid_o
- axi_aw_id/addr/len/size/burst/valid  out  AXI4 widths  write address channel
- axi_aw_lock/cache/prot/qos/region/user  out  AXI4 widths  write sideband, constant
- axi_aw_ready  in  1
- axi_w_data/strb/last/user/valid  out  AXI4 widths  write data channel
- axi_w_ready  in  1
- axi_b_id/resp/user/valid  in  AXI4 widths  write response channel
- axi_b_ready  out  1
- axi_ar_id/addr/len/size/burst/valid  out  AXI4 widths  read address channel
- axi_ar_lock/cache/prot/qos/region/user  out  AXI4 widths  read sideband, constant
- axi_ar_ready  in  1
- axi_r_id/data/resp/last/user/valid  in  AXI4 widths  read data channel
- axi_r_ready  out  1

Behaviour:
- Reset (rst_i high at a clock edge):
  - state returns to IDLE
  - all axi_*_valid, axi_b_ready, axi_r_ready, gnt_o, rvalid_o, err_o go to 0; rdata_o goes to 0
  - applies mid-transaction as well: valids drop in the cycle after the reset edge and the in-flight transaction is abandoned
- Constant fields:
  - len = 0, size = log2(AXI_STRB_WIDTH), burst = INCR (2'b01)
  - lock = 0, cache = 4'b0011, prot = 3'b000, qos = 0, region = 0, user = 0
  - id = AXI_ID, w_last = 1
- gnt_o = req_i && state==IDLE, combinational. On a grant edge addr/we/be/wdata are registered; native inputs are don't-care afterwards.
- FSM:
  - IDLE: on grant, go to WR if we_i, else RD.
  - WR: aw_valid and w_valid are both asserted from the first cycle. Each is held, with stable payload, until its own handshake and then deasserts independently. Either order is accepted, including both handshaking in the same cycle. Once both handshakes have completed, go to WRESP.
  - WRESP: b_ready = 1. On b_valid: rvalid_o = 1 next cycle, err_o = b_resp[1], rdata_o unchanged; go to IDLE.
  - RD: ar_valid held until ar_ready, then go to RDATA.
  - RDATA: r_ready = 1.
    - On r_valid && r_last: rdata_o <= r_data, err_o <= r_resp[1], rvalid_o = 1 next cycle; go to IDLE.
    - Beats with r_last = 0 (protocol violation) are accepted and discarded; the bench flags them.
- Minimum latency with ready/valid always high: grant at cycle T, AW/W/AR valid at T+1, response handshake at T+2, rvalid_o at T+3.
- Back-to-back requests: the earliest re-grant is the cycle in which rvalid_o is high (state is already IDLE).
- B/R IDs are not checked. B/R user fields are ignored.
- Response channels are never back-pressured outside WRESP/RDATA.

Decomposition:
- Package peripheral_axi4_pkg holds:
  - burst constants FIXED/INCR/WRAP and response constants OKAY/EXOKAY/SLVERR/DECERR
  - the FSM state enum {IDLE, WR, WRESP, RD, RDATA}
  - the default cache/prot values
- A single flat module is sufficient; no sub-module.

Test Plan:
- Write with all readies high: addr = 0x40, wdata = 0xDEADBEEF_CAFEF00D, be = 0xFF -> aw_valid/w_valid at T+1 with aw_addr = 0x40, w_strb = 0xFF, w_last = 1; rvalid_o at T+3 with err_o = 0.
- Read with ar_ready delayed 3 cycles and r_valid 2 cycles after the AR handshake, r_data = 0x0123456789ABCDEF, r_resp = OKAY -> ar_valid and ar_addr stable throughout the stall; rdata_o = 0x0123456789ABCDEF with a single rvalid_o pulse.
- Write where w_ready arrives 4 cycles before aw_ready -> w_valid drops after its handshake, aw_valid is held, and b_ready rises only after the AW handshake.
- Read returning r_resp = SLVERR, then a write returning b_resp = DECERR -> err_o = 1 on both rvalid_o pulses.
- Assert rst_i for one cycle during WRESP, then issue a read -> all valids/readies are 0 the cycle after the reset edge, no rvalid_o pulse for the abandoned write, and the next read completes normally.
- Two back-to-back reads with req_i held high -> the second gnt_o coincides with the first rvalid_o; the AR addresses are issued in order.

Source files
------------

// File: rtl/peripheral_axi4_pkg.sv
// Shared AXI4 encodings and FSM state type for the SPRAM AXI4 initiator.
// Burst/response codes are kept here so benches and sibling blocks agree on them.
package peripheral_axi4_pkg;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD,
        RDATA
    } state_t;

endpackage

// File: rtl/peripheral_spram_axi4_initiator.sv
// Native single-port memory request -> single-beat AXI4 master transactions.
// One transaction in flight; completion is reported as a one-cycle rvalid_o pulse.
module peripheral_spram_axi4_initiator
    import peripheral_axi4_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_STRB_WIDTH = 8,
    parameter int AXI_USER_WIDTH = 10,
    parameter int AXI_ID         = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [AXI_STRB_WIDTH-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,

    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    output logic [7:0]                axi_aw_len,
    output logic [2:0]                axi_aw_size,
    output logic [1:0]                axi_aw_burst,
    output logic                      axi_aw_lock,
    output logic [3:0]                axi_aw_cache,
    output logic [2:0]                axi_aw_prot,
    output logic [3:0]                axi_aw_qos,
    output logic [3:0]                axi_aw_region,
    output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
    output logic                      axi_aw_valid,
    input  logic                      axi_aw_ready,

    output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
    output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
    output logic                      axi_w_last,
    output logic [AXI_USER_WIDTH-1:0] axi_w_user,
    output logic                      axi_w_valid,
    input  logic                      axi_w_ready,

    input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
    input  logic [1:0]                axi_b_resp,
    input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
    input  logic                      axi_b_valid,
    output logic                      axi_b_ready,

    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    output logic [7:0]                axi_ar_len,
    output logic [2:0]                axi_ar_size,
    output logic [1:0]                axi_ar_burst,
    output logic                      axi_ar_lock,
    output logic [3:0]                axi_ar_cache,
    output logic [2:0]                axi_ar_prot,
    output logic [3:0]                axi_ar_qos,
    output logic [3:0]                axi_ar_region,
    output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
    output logic                      axi_ar_valid,
    input  logic                      axi_ar_ready,

    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    input  logic [1:0]                axi_r_resp,
    input  logic                      axi_r_last,
    input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
    input  logic                      axi_r_valid,
    output logic                      axi_r_ready
);

    localparam logic [2:0] BEAT_SIZE = 3'($clog2(AXI_STRB_WIDTH));

    state_t                    state_reg;
    logic [AXI_ADDR_WIDTH-1:0] addr_reg;
    logic [AXI_STRB_WIDTH-1:0] be_reg;
    logic [AXI_DATA_WIDTH-1:0] wdata_reg;
    logic                      aw_valid_reg;
    logic                      w_valid_reg;
    logic                      ar_valid_reg;
    logic                      b_ready_reg;
    logic                      r_ready_reg;
    logic                      rvalid_reg;
    logic                      err_reg;
    logic [AXI_DATA_WIDTH-1:0] rdata_reg;
    logic                      aw_clear;
    logic                      w_clear;

    // IDs, user fields and the low response bit carry no information for this initiator.
    logic unused_inputs;
    assign unused_inputs = ^{axi_b_id, axi_b_user, axi_b_resp[0],
                             axi_r_id, axi_r_user, axi_r_resp[0]};

    assign gnt_o = req_i && (state_reg == IDLE) && !rst_i;

    // A channel is finished once it is no longer valid or completes its handshake now.
    assign aw_clear = !aw_valid_reg || axi_aw_ready;
    assign w_clear  = !w_valid_reg  || axi_w_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
            aw_valid_reg <= 1'b0;
            w_valid_reg  <= 1'b0;
            ar_valid_reg <= 1'b0;
            b_ready_reg  <= 1'b0;
            r_ready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            err_reg      <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            rvalid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (gnt_o) begin
                        addr_reg  <= addr_i;
                        be_reg    <= be_i;
                        wdata_reg <= wdata_i;
                        if (we_i) begin
                            aw_valid_reg <= 1'b1;
                            w_valid_reg  <= 1'b1;
                            state_reg    <= WR;
                        end else begin
                            ar_valid_reg <= 1'b1;
                            state_reg    <= RD;
                        end
                    end
                end
                WR: begin
                    if (axi_aw_ready) aw_valid_reg <= 1'b0;
                    if (axi_w_ready)  w_valid_reg  <= 1'b0;
                    if (aw_clear && w_clear) begin
                        b_ready_reg <= 1'b1;
                        state_reg   <= WRESP;
                    end
                end
                WRESP: begin
                    if (axi_b_valid) begin
                        b_ready_reg <= 1'b0;
                        rvalid_reg  <= 1'b1;
                        err_reg     <= axi_b_resp[1];
                        state_reg   <= IDLE;
                    end
                end
                RD: begin
                    if (axi_ar_ready) begin
                        ar_valid_reg <= 1'b0;
                        r_ready_reg  <= 1'b1;
                        state_reg    <= RDATA;
                    end
                end
                RDATA: begin
                    // Non-last beats are consumed and dropped; only the last beat completes.
                    if (axi_r_valid && axi_r_last) begin
                        r_ready_reg <= 1'b0;
                        rdata_reg   <= axi_r_data;
                        err_reg     <= axi_r_resp[1];
                        rvalid_reg  <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rvalid_o = rvalid_reg;
    assign rdata_o  = rdata_reg;
    assign err_o    = err_reg;

    assign axi_aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_aw_addr   = addr_reg;
    assign axi_aw_len    = 8'd0;
    assign axi_aw_size   = BEAT_SIZE;
    assign axi_aw_burst  = INCR;
    assign axi_aw_lock   = 1'b0;
    assign axi_aw_cache  = CACHE_DEFAULT;
    assign axi_aw_prot   = PROT_DEFAULT;
    assign axi_aw_qos    = 4'd0;
    assign axi_aw_region = 4'd0;
    assign axi_aw_user   = '0;
    assign axi_aw_valid  = aw_valid_reg;

    assign axi_w_data    = wdata_reg;
    assign axi_w_strb    = be_reg;
    assign axi_w_last    = 1'b1;
    assign axi_w_user    = '0;
    assign axi_w_valid   = w_valid_reg;

    assign axi_b_ready   = b_ready_reg;

    assign axi_ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_ar_addr   = addr_reg;
    assign axi_ar_len    = 8'd0;
    assign axi_ar_size   = BEAT_SIZE;
    assign axi_ar_burst  = INCR;
    assign axi_ar_lock   = 1'b0;
    assign axi_ar_cache  = CACHE_DEFAULT;
    assign axi_ar_prot   = PROT_DEFAULT;
    assign axi_ar_qos    = 4'd0;
    assign axi_ar_region = 4'd0;
    assign axi_ar_user   = '0;
    assign axi_ar_valid  = ar_valid_reg;

    assign axi_r_ready   = r_ready_reg;

endmodule

// File: tb/tb_peripheral_spram_axi4_initiator.sv
// Directed bench for the SPRAM AXI4 initiator: a transaction table driven through a
// cycle-level responder model, plus hand sequences for mid-WRESP reset and back-to-back reads.
module tb_peripheral_spram_axi4_initiator;
    import peripheral_axi4_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [63:0] addr_i = '0;
    logic [7:0]  be_i = '0;
    logic [63:0] wdata_i = '0;
    logic        gnt_o, rvalid_o, err_o;
    logic [63:0] rdata_o;

    logic [9:0]  aw_id, ar_id, aw_user, ar_user, w_user;
    logic [63:0] aw_addr, ar_addr, w_data;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst;
    logic        aw_lock, ar_lock, aw_valid, ar_valid, w_last, w_valid, b_ready, r_ready;
    logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic        aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
    logic        b_valid = 1'b0, r_valid = 1'b0, r_last = 1'b1;
    logic [1:0]  b_resp = '0, r_resp = '0;
    logic [63:0] r_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    peripheral_spram_axi4_initiator #(
        .AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
        .AXI_STRB_WIDTH(8), .AXI_USER_WIDTH(10), .AXI_ID(0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .axi_aw_id(aw_id), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len), .axi_aw_size(aw_size),
        .axi_aw_burst(aw_burst), .axi_aw_lock(aw_lock), .axi_aw_cache(aw_cache),
        .axi_aw_prot(aw_prot), .axi_aw_qos(aw_qos), .axi_aw_region(aw_region),
        .axi_aw_user(aw_user), .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
        .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_last(w_last), .axi_w_user(w_user),
        .axi_w_valid(w_valid), .axi_w_ready(w_ready),
        .axi_b_id(10'd0), .axi_b_resp(b_resp), .axi_b_user(10'd0), .axi_b_valid(b_valid),
        .axi_b_ready(b_ready),
        .axi_ar_id(ar_id), .axi_ar_addr(ar_addr), .axi_ar_len(ar_len), .axi_ar_size(ar_size),
        .axi_ar_burst(ar_burst), .axi_ar_lock(ar_lock), .axi_ar_cache(ar_cache),
        .axi_ar_prot(ar_prot), .axi_ar_qos(ar_qos), .axi_ar_region(ar_region),
        .axi_ar_user(ar_user), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
        .axi_r_id(10'd0), .axi_r_data(r_data), .axi_r_resp(r_resp), .axi_r_last(r_last),
        .axi_r_user(10'd0), .axi_r_valid(r_valid), .axi_r_ready(r_ready)
    );

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        int          a_dly;     // address-channel ready arrives in cycle a_dly+1
        int          w_dly;     // write-data ready arrives in cycle w_dly+1
        int          resp_dly;  // cycles from response phase start to B/R valid
        logic [63:0] rdata;
        logic [1:0]  resp;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_resp_inputs();
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_valid = 1'b0; r_valid = 1'b0; b_resp = OKAY; r_resp = OKAY; r_data = '0;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        bit   aw_done, w_done, ar_done, resp_done, got;
        int   resp_start;
        logic aw_exp, w_exp, ar_exp, b_exp, r_exp;
        aw_done = !v.we; w_done = !v.we; ar_done = v.we;
        resp_done = 0; got = 0; resp_start = -1;
        @(negedge clk_i);
        req_i = 1'b1; we_i = v.we; addr_i = v.addr; be_i = v.be; wdata_i = v.wdata;
        #1 check("gnt", 64'(gnt_o), 64'd1);
        @(posedge clk_i);
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk_i);
            req_i = 1'b0; we_i = ~v.we; addr_i = '1; be_i = '0; wdata_i = '0;
            if (resp_done) begin
                check("rvalid_pulse", 64'(rvalid_o), 64'd1);
                check("rdata", rdata_o, v.exp_rdata);
                check("err", 64'(err_o), 64'(v.exp_err));
                clear_resp_inputs();
                got = 1;
            end else begin
                aw_exp = !aw_done; w_exp = !w_done; ar_exp = !ar_done;
                b_exp = v.we && aw_done && w_done;
                r_exp = !v.we && ar_done;
                check("aw_valid", 64'(aw_valid), 64'(aw_exp));
                check("w_valid", 64'(w_valid), 64'(w_exp));
                check("ar_valid", 64'(ar_valid), 64'(ar_exp));
                check("b_ready", 64'(b_ready), 64'(b_exp));
                check("r_ready", 64'(r_ready), 64'(r_exp));
                check("rvalid_idle", 64'(rvalid_o), 64'd0);
                if (aw_exp) check("aw_addr", aw_addr, v.addr);
                if (w_exp) begin
                    check("w_data", w_data, v.wdata);
                    check("w_strb", 64'(w_strb), 64'(v.be));
                end
                if (ar_exp) check("ar_addr", ar_addr, v.addr);
                if ((b_exp || r_exp) && resp_start < 0) resp_start = k;
                aw_ready = (k > v.a_dly);
                ar_ready = (k > v.a_dly);
                w_ready  = (k > v.w_dly);
                b_valid  = b_exp && (k - resp_start >= v.resp_dly);
                r_valid  = r_exp && (k - resp_start >= v.resp_dly);
                b_resp   = v.resp;
                r_resp   = v.resp;
                r_data   = r_valid ? v.rdata : 64'h5555_5555_5555_5555;
                if (aw_exp && aw_ready) aw_done = 1;
                if (w_exp && w_ready) w_done = 1;
                if (ar_exp && ar_ready) ar_done = 1;
                if ((b_exp && b_valid) || (r_exp && r_valid)) resp_done = 1;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL txn%0d_timeout: got no rvalid_o expected pulse within 40 cycles", idx);
            clear_resp_inputs();
        end
        @(negedge clk_i);
        check("rvalid_single", 64'(rvalid_o), 64'd0);
        $display("txn %0d %s addr=0x%0h rdata=0x%0h err=%0d", idx, v.we ? "WR" : "RD",
                 v.addr, rdata_o, err_o);
    endtask

    initial begin
        vecs[0] = '{1'b1, 64'h40, 8'hFF, 64'hDEADBEEF_CAFEF00D, 0, 0, 0,
                    64'h0, OKAY, 64'h0, 1'b0};
        vecs[1] = '{1'b0, 64'h1000, 8'h00, 64'h0, 3, 0, 1,
                    64'h0123456789ABCDEF, OKAY, 64'h0123456789ABCDEF, 1'b0};
        vecs[2] = '{1'b1, 64'h88, 8'h0F, 64'h11112222_33334444, 4, 0, 0,
                    64'h0, OKAY, 64'h0123456789ABCDEF, 1'b0};
        vecs[3] = '{1'b0, 64'h2000, 8'h00, 64'h0, 0, 0, 0,
                    64'hA5A5A5A5_A5A5A5A5, SLVERR, 64'hA5A5A5A5_A5A5A5A5, 1'b1};
        vecs[4] = '{1'b1, 64'h18, 8'hF0, 64'h99998888_77776666, 0, 0, 0,
                    64'h0, DECERR, 64'hA5A5A5A5_A5A5A5A5, 1'b1};
        vecs[5] = '{1'b1, 64'h300, 8'h3C, 64'hCAFE0000_0000BEEF, 0, 2, 3,
                    64'h0, OKAY, 64'hA5A5A5A5_A5A5A5A5, 1'b0};
        vecs[6] = '{1'b0, 64'h7F8, 8'h00, 64'h0, 1, 0, 2,
                    64'hFEDCBA98_76543210, EXOKAY, 64'hFEDCBA98_76543210, 1'b0};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_aw_valid", 64'(aw_valid), 64'd0);
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        check("rst_r_ready", 64'(r_ready), 64'd0);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_rdata", rdata_o, 64'd0);
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("aw_len", 64'(aw_len), 64'd0);
        check("aw_size", 64'(aw_size), 64'd3);
        check("aw_burst", 64'(aw_burst), 64'(INCR));
        check("aw_cache", 64'(aw_cache), 64'h3);
        check("aw_id", 64'(aw_id), 64'd0);
        check("ar_size", 64'(ar_size), 64'd3);
        check("ar_burst", 64'(ar_burst), 64'(INCR));
        check("ar_cache", 64'(ar_cache), 64'h3);
        check("w_last", 64'(w_last), 64'd1);
        check("sideband", 64'({aw_lock, aw_prot, aw_qos, aw_region, aw_user, w_user,
                               ar_lock, ar_prot, ar_qos, ar_region, ar_user, ar_len, ar_id}), 64'd0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

        // Reset while the write waits for its B response.
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 64'h70; be_i = 8'hFF; wdata_i = 64'h1234;
        #1 check("rstseq_gnt", 64'(gnt_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
        check("rstseq_aw_valid", 64'(aw_valid), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("rstseq_b_ready", 64'(b_ready), 64'd1);
        aw_ready = 1'b0; w_ready = 1'b0; rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rstseq_valids", 64'({aw_valid, w_valid, ar_valid}), 64'd0);
        check("rstseq_readies", 64'({b_ready, r_ready}), 64'd0);
        check("rstseq_rdata", rdata_o, 64'd0);
        b_valid = 1'b1; b_resp = OKAY;
        for (int i = 0; i < 3; i++) begin
            check("rstseq_no_rvalid", 64'(rvalid_o), 64'd0);
            @(negedge clk_i);
        end
        check("rstseq_no_rvalid", 64'(rvalid_o), 64'd0);
        b_valid = 1'b0;
        run_txn(vecs[1], 7);

        // Back-to-back reads with req_i held high.
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 64'hA00;
        #1 check("b2b_gnt1", 64'(gnt_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        addr_i = 64'hB00; ar_ready = 1'b1;
        check("b2b_ar_addr1", ar_addr, 64'hA00);
        check("b2b_ar_valid1", 64'(ar_valid), 64'd1);
        #1 check("b2b_no_gnt_rd", 64'(gnt_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        ar_ready = 1'b0; r_valid = 1'b1; r_last = 1'b1; r_resp = OKAY; r_data = 64'h1111;
        check("b2b_r_ready1", 64'(r_ready), 64'd1);
        #1 check("b2b_no_gnt_rdata", 64'(gnt_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        r_valid = 1'b0;
        check("b2b_rvalid1", 64'(rvalid_o), 64'd1);
        check("b2b_rdata1", rdata_o, 64'h1111);
        #1 check("b2b_gnt2", 64'(gnt_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0; ar_ready = 1'b1;
        check("b2b_ar_valid2", 64'(ar_valid), 64'd1);
        check("b2b_ar_addr2", ar_addr, 64'hB00);
        @(posedge clk_i);
        @(negedge clk_i);
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'h2222;
        @(posedge clk_i);
        @(negedge clk_i);
        r_valid = 1'b0;
        check("b2b_rvalid2", 64'(rvalid_o), 64'd1);
        check("b2b_rdata2", rdata_o, 64'h2222);
        $display("txn b2b reads 0xA00/0xB00 rdata=0x%0h", rdata_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
